// File: rtl/mem_slave_pkg.sv
// Shared definitions for the memory slave: the FSM state type, the default
// parameter values and the byte-lane merge helper used for strobed writes.
package mem_slave_pkg;

   localparam int DEFAULT_DEPTH_WORDS = 256;
   localparam int DEFAULT_WAIT_CYCLES = 0;
   localparam int DEFAULT_ADDR_LIMIT  = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Replace the bytes of oldWord whose strobe is set with the matching bytes of newWord.
   function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  strb);
      logic [31:0] result;
      for (int b = 0; b < 4; b++) begin
         result[8*b +: 8] = strb[b] ? newWord[8*b +: 8] : oldWord[8*b +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/mem_slave_ram_array.sv
// Word RAM with a byte-enabled bus write port and a full-word preload port.
// The read port is asynchronous, so a register loaded from it on a write edge
// captures the word as it was before that edge's write. No reset: contents
// survive a reset of the surrounding logic.
module mem_slave_ram_array
   import mem_slave_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_i,
   input  logic [AW-1:0] busIdx_i,
   output logic [31:0]   rdData_o,
   input  logic          wrEn_i,
   input  logic [3:0]    wrStrb_i,
   input  logic [31:0]   wrData_i,
   input  logic          ldWe_i,
   input  logic [AW-1:0] ldIdx_i,
   input  logic [31:0]   ldData_i
);

   logic [31:0] mem [DEPTH_WORDS];

   assign rdData_o = mem[busIdx_i];

   // Preload and bus writes; the caller keeps them off the same word in one edge.
   always_ff @(posedge clk_i) begin
      if (ldWe_i) begin
         mem[ldIdx_i] <= ldData_i;
      end
      if (wrEn_i) begin
         mem[busIdx_i] <= mergeBytes(mem[busIdx_i], wrData_i, wrStrb_i);
      end
   end

endmodule

// File: rtl/mem_slave_ram.sv
// Single-port memory slave for a simple valid/ready core bus. Each request is
// answered with a one-cycle mem_ready pulse after WAIT_CYCLES extra cycles.
// A side preload port can fill the RAM at any time, including during reset.
module mem_slave_ram
   import mem_slave_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
   parameter int ADDR_LIMIT  = DEFAULT_ADDR_LIMIT
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           mem_valid,
   input  logic                           mem_instr,
   input  logic [31:0]                    mem_addr,
   input  logic [31:0]                    mem_wdata,
   input  logic [3:0]                     mem_wstrb,
   output logic                           mem_ready,
   output logic [31:0]                    mem_rdata,
   input  logic                           ld_valid,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
   input  logic [31:0]                    ld_data,
   output logic                           st_pulse,
   output logic [31:0]                    st_addr,
   output logic [31:0]                    st_data,
   output logic                           bus_err,
   output logic [15:0]                    fetch_cnt,
   output logic [15:0]                    store_cnt
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_e      state_q, state_d;
   logic [3:0]  waitCnt_q, waitCnt_d;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic        instr_q;
   logic        capture;
   logic        goResp;

   logic [31:0] accAddr, accWdata;
   logic [3:0]  accWstrb;
   logic        accInstr;
   logic        inRange;
   logic [AW-1:0] accIdx;
   logic [31:0] rdWord, storeWord;
   logic        busWe, ldWe;

   logic [31:0] rdata_q, stAddr_q, stData_q;
   logic        stPulse_q, busErr_q;
   logic [15:0] fetchCnt_q, storeCnt_q;

   // Next-state logic; the access fields come straight from the bus when the
   // request goes to RESP on its acceptance edge, otherwise from the capture.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      capture   = 1'b0;
      goResp    = 1'b0;
      accAddr   = addr_q;
      accWdata  = wdata_q;
      accWstrb  = wstrb_q;
      accInstr  = instr_q;
      case (state_q)
         IDLE: begin
            if (mem_valid && !ld_valid) begin
               capture  = 1'b1;
               accAddr  = mem_addr;
               accWdata = mem_wdata;
               accWstrb = mem_wstrb;
               accInstr = mem_instr;
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
                  goResp  = 1'b1;
               end else begin
                  state_d   = WAIT;
                  waitCnt_d = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (waitCnt_q == 4'd0) begin
               state_d = RESP;
               goResp  = 1'b1;
            end else begin
               waitCnt_d = waitCnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign inRange   = (accAddr < 32'(ADDR_LIMIT));
   assign accIdx    = accAddr[AW+1:2];
   assign storeWord = mergeBytes(rdWord, accWdata, accWstrb);
   assign busWe     = resetn && goResp && inRange && (accWstrb != 4'b0000);
   assign ldWe      = ld_valid && !(busWe && (ld_addr == accIdx));

   mem_slave_ram_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk_i    (clk),
      .busIdx_i (accIdx),
      .rdData_o (rdWord),
      .wrEn_i   (busWe),
      .wrStrb_i (accWstrb),
      .wrData_i (accWdata),
      .ldWe_i   (ldWe),
      .ldIdx_i  (ld_addr),
      .ldData_i (ld_data)
   );

   // State register, wait counter and request capture.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         waitCnt_q <= 4'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         instr_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         if (capture) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            instr_q <= mem_instr;
         end
      end
   end

   // Response data, store report, sticky error and saturating counters.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdata_q    <= 32'd0;
         stPulse_q  <= 1'b0;
         stAddr_q   <= 32'd0;
         stData_q   <= 32'd0;
         busErr_q   <= 1'b0;
         fetchCnt_q <= 16'd0;
         storeCnt_q <= 16'd0;
      end else begin
         stPulse_q <= 1'b0;
         if (goResp) begin
            rdata_q <= inRange ? rdWord : 32'd0;
            if (!inRange) begin
               busErr_q <= 1'b1;
            end
            if (inRange && (accWstrb != 4'b0000)) begin
               stPulse_q <= 1'b1;
               stAddr_q  <= accAddr;
               stData_q  <= storeWord;
               if (storeCnt_q != 16'hFFFF) begin
                  storeCnt_q <= storeCnt_q + 16'd1;
               end
            end
            if (accInstr && (fetchCnt_q != 16'hFFFF)) begin
               fetchCnt_q <= fetchCnt_q + 16'd1;
            end
         end
      end
   end

   assign mem_ready = (state_q == RESP);
   assign mem_rdata = rdata_q;
   assign st_pulse  = stPulse_q;
   assign st_addr   = stAddr_q;
   assign st_data   = stData_q;
   assign bus_err   = busErr_q;
   assign fetch_cnt = fetchCnt_q;
   assign store_cnt = storeCnt_q;

endmodule

// File: tb/tb_mem_slave_ram.sv
// Bench for mem_slave_ram: a zero-wait instance driven from a vector table
// with a response scoreboard, and a three-wait instance for timing and
// mid-transaction reset sequences.
module tb_mem_slave_ram;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid, mem_instr;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        ld_valid;
   logic [7:0]  ld_addr;
   logic [31:0] ld_data;
   logic        st_pulse, bus_err;
   logic [31:0] st_addr, st_data;
   logic [15:0] fetch_cnt, store_cnt;

   logic        w3_resetn;
   logic        w3_valid, w3_instr;
   logic [31:0] w3_addr, w3_wdata;
   logic [3:0]  w3_wstrb;
   logic        w3_ready;
   logic [31:0] w3_rdata;
   logic        w3_ld_valid;
   logic [7:0]  w3_ld_addr;
   logic [31:0] w3_ld_data;
   logic        w3_st_pulse, w3_bus_err;
   logic [31:0] w3_st_addr, w3_st_data;
   logic [15:0] w3_fetch_cnt, w3_store_cnt;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        instr;
      logic [31:0] expRdata;
      logic        expSt;
      logic [31:0] expStData;
   } vecT;

   typedef struct {
      logic [31:0] rdata;
      logic        st;
      logic [31:0] stData;
      logic [31:0] stAddr;
   } expT;

   expT expQ[$];
   vecT vecs[8];
   int  testsRun = 0;
   int  testsFailed = 0;

   mem_slave_ram #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_LIMIT(1024)) dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .st_pulse(st_pulse), .st_addr(st_addr), .st_data(st_data),
      .bus_err(bus_err), .fetch_cnt(fetch_cnt), .store_cnt(store_cnt)
   );

   mem_slave_ram #(.DEPTH_WORDS(256), .WAIT_CYCLES(3), .ADDR_LIMIT(1024)) dut3 (
      .clk(clk), .resetn(w3_resetn),
      .mem_valid(w3_valid), .mem_instr(w3_instr), .mem_addr(w3_addr),
      .mem_wdata(w3_wdata), .mem_wstrb(w3_wstrb),
      .mem_ready(w3_ready), .mem_rdata(w3_rdata),
      .ld_valid(w3_ld_valid), .ld_addr(w3_ld_addr), .ld_data(w3_ld_data),
      .st_pulse(w3_st_pulse), .st_addr(w3_st_addr), .st_data(w3_st_data),
      .bus_err(w3_bus_err), .fetch_cnt(w3_fetch_cnt), .store_cnt(w3_store_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One bus request on the zero-wait instance; the expected response goes to the scoreboard.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                                input logic ins, input expT e);
      int n;
      expQ.push_back(e);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = wd;
      mem_wstrb = ws;
      mem_instr = ins;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_ready && n < 20);
      checkOutput("readyLatency", 32'(n), 32'd1);
      mem_valid = 1'b0;
      mem_wstrb = 4'b0000;
      mem_instr = 1'b0;
      @(negedge clk);
      checkOutput("readyWidth", {31'b0, mem_ready}, 32'd0);
      checkOutput("stPulseWidth", {31'b0, st_pulse}, 32'd0);
   endtask

   // Scoreboard: every mem_ready pulse consumes one expected response.
   always @(negedge clk) begin
      if (mem_ready) begin
         checkOutput("pendingExp", 32'(expQ.size()), 32'd1);
         if (expQ.size() > 0) begin
            expT e;
            e = expQ.pop_front();
            checkOutput("rdata", mem_rdata, e.rdata);
            checkOutput("stPulse", {31'b0, st_pulse}, {31'b0, e.st});
            if (e.st) begin
               checkOutput("stData", st_data, e.stData);
               checkOutput("stAddr", st_addr, e.stAddr);
            end
         end
      end
   end

   initial begin
      vecs[0] = '{32'h0000_0004, 32'h0,          4'b0000, 1'b1, 32'h00A0_0193, 1'b0, 32'h0};
      vecs[1] = '{32'h0000_0008, 32'hDEAD_BEEF, 4'b0101, 1'b0, 32'h1122_3344, 1'b1, 32'h11AD_33EF};
      vecs[2] = '{32'h0000_0008, 32'h0,          4'b0000, 1'b0, 32'h11AD_33EF, 1'b0, 32'h0};
      vecs[3] = '{32'h0000_000C, 32'h1234_5678, 4'b1111, 1'b0, 32'hCAFE_F00D, 1'b1, 32'h1234_5678};
      vecs[4] = '{32'h0000_0000, 32'hAABB_CCDD, 4'b1000, 1'b0, 32'h0BAD_F00D, 1'b1, 32'hAAAD_F00D};
      vecs[5] = '{32'h0000_0000, 32'h0,          4'b0000, 1'b1, 32'hAAAD_F00D, 1'b0, 32'h0};
      vecs[6] = '{32'h0000_03FC, 32'h0,          4'b0000, 1'b0, 32'h55AA_55AA, 1'b0, 32'h0};
      vecs[7] = '{32'h0000_000E, 32'h0,          4'b0000, 1'b0, 32'h1234_5678, 1'b0, 32'h0};

      resetn = 1'b0; w3_resetn = 1'b0;
      mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
      ld_valid = 1'b0; ld_addr = 8'h0; ld_data = 32'h0;
      w3_valid = 1'b0; w3_instr = 1'b0; w3_addr = 32'h0; w3_wdata = 32'h0; w3_wstrb = 4'h0;
      w3_ld_valid = 1'b0; w3_ld_addr = 8'h0; w3_ld_data = 32'h0;

      // Preload through the side port while both instances are held in reset.
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 8'd0; ld_data = 32'h0BAD_F00D;
      w3_ld_valid = 1'b1; w3_ld_addr = 8'd0; w3_ld_data = 32'h1357_9BDF;
      @(negedge clk);
      ld_addr = 8'd1; ld_data = 32'h00A0_0193;
      w3_ld_addr = 8'd3; w3_ld_data = 32'h3333_3333;
      @(negedge clk);
      ld_addr = 8'd2; ld_data = 32'h1122_3344;
      w3_ld_valid = 1'b0;
      @(negedge clk);
      ld_addr = 8'd3; ld_data = 32'hCAFE_F00D;
      @(negedge clk);
      ld_addr = 8'd255; ld_data = 32'h55AA_55AA;
      @(negedge clk);
      ld_valid = 1'b0;
      checkOutput("rstReady", {31'b0, mem_ready}, 32'd0);
      checkOutput("rstRdata", mem_rdata, 32'd0);
      checkOutput("rstStPulse", {31'b0, st_pulse}, 32'd0);
      checkOutput("rstBusErr", {31'b0, bus_err}, 32'd0);
      checkOutput("rstFetchCnt", {16'b0, fetch_cnt}, 32'd0);
      checkOutput("rstStoreCnt", {16'b0, store_cnt}, 32'd0);
      checkOutput("rstStAddr", st_addr, 32'd0);
      checkOutput("rstStData", st_data, 32'd0);
      resetn = 1'b1; w3_resetn = 1'b1;
      @(negedge clk);

      // Table-driven reads, fetches and strobed stores.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].instr,
                       '{vecs[i].expRdata, vecs[i].expSt, vecs[i].expStData, vecs[i].addr});
      end
      checkOutput("fetchCnt", {16'b0, fetch_cnt}, 32'd2);
      checkOutput("storeCnt", {16'b0, store_cnt}, 32'd3);
      checkOutput("busErrClean", {31'b0, bus_err}, 32'd0);

      // Out-of-range read and store: zero data, no store report, sticky error.
      applyStimulus(32'h0000_0400, 32'h0, 4'b0000, 1'b0, '{32'h0, 1'b0, 32'h0, 32'h0});
      checkOutput("busErrSet", {31'b0, bus_err}, 32'd1);
      applyStimulus(32'h0000_0404, 32'hFFFF_FFFF, 4'b1111, 1'b0, '{32'h0, 1'b0, 32'h0, 32'h0});
      checkOutput("storeCntOor", {16'b0, store_cnt}, 32'd3);
      repeat (3) @(negedge clk);
      checkOutput("busErrSticky", {31'b0, bus_err}, 32'd1);

      // Preload and bus request together for two cycles: preload first, then acceptance.
      ld_valid = 1'b1; ld_addr = 8'd4; ld_data = 32'h600D_CAFE;
      mem_valid = 1'b1; mem_addr = 32'h0000_0010; mem_wstrb = 4'b0000; mem_instr = 1'b0;
      expQ.push_back('{32'h600D_CAFE, 1'b0, 32'h0, 32'h0});
      @(negedge clk);
      checkOutput("collideHold1", {31'b0, mem_ready}, 32'd0);
      @(negedge clk);
      checkOutput("collideHold2", {31'b0, mem_ready}, 32'd0);
      ld_valid = 1'b0;
      @(negedge clk);
      checkOutput("collideAccept", {31'b0, mem_ready}, 32'd1);
      mem_valid = 1'b0;
      @(negedge clk);

      // Zero-wait instance reset: error clears, counters clear, RAM retained.
      resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst2BusErr", {31'b0, bus_err}, 32'd0);
      checkOutput("rst2FetchCnt", {16'b0, fetch_cnt}, 32'd0);
      checkOutput("rst2Rdata", mem_rdata, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      applyStimulus(32'h0000_0004, 32'h0, 4'b0000, 1'b0, '{32'h00A0_0193, 1'b0, 32'h0, 32'h0});

      // Three-wait instance: ready exactly four edges after valid, one cycle wide.
      w3_valid = 1'b1; w3_addr = 32'h0; w3_instr = 1'b1; w3_wstrb = 4'b0000;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         checkOutput($sformatf("w3ReadyEdge%0d", i), {31'b0, w3_ready}, {31'b0, (i == 4)});
         if (w3_ready) begin
            checkOutput("w3Rdata", w3_rdata, 32'h1357_9BDF);
            w3_valid = 1'b0;
            w3_instr = 1'b0;
         end
      end
      checkOutput("w3FetchCnt", {16'b0, w3_fetch_cnt}, 32'd1);

      // Reset while a store to 0xC is waiting: nothing commits, outputs clear.
      w3_valid = 1'b1; w3_addr = 32'h0000_000C; w3_wdata = 32'hFFFF_FFFF; w3_wstrb = 4'b1111;
      @(negedge clk);
      w3_valid = 1'b0; w3_wstrb = 4'b0000;
      @(negedge clk);
      w3_resetn = 1'b0;
      @(negedge clk);
      checkOutput("w3RstReady1", {31'b0, w3_ready}, 32'd0);
      @(negedge clk);
      checkOutput("w3RstReady2", {31'b0, w3_ready}, 32'd0);
      checkOutput("w3RstRdata", w3_rdata, 32'd0);
      checkOutput("w3RstStPulse", {31'b0, w3_st_pulse}, 32'd0);
      checkOutput("w3RstStAddr", w3_st_addr, 32'd0);
      checkOutput("w3RstStData", w3_st_data, 32'd0);
      checkOutput("w3RstBusErr", {31'b0, w3_bus_err}, 32'd0);
      checkOutput("w3RstFetchCnt", {16'b0, w3_fetch_cnt}, 32'd0);
      checkOutput("w3RstStoreCnt", {16'b0, w3_store_cnt}, 32'd0);
      w3_resetn = 1'b1;
      @(negedge clk);
      checkOutput("w3RstReady3", {31'b0, w3_ready}, 32'd0);

      // Read word 3 back with valid dropped while waiting; the request still completes.
      w3_valid = 1'b1; w3_addr = 32'h0000_000C;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         w3_valid = 1'b0;
         checkOutput($sformatf("w3DropEdge%0d", i), {31'b0, w3_ready}, {31'b0, (i == 4)});
      end
      checkOutput("w3Word3Kept", w3_rdata, 32'h3333_3333);
      @(negedge clk);

      checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/mem_slave_ram.md
MEM_SLAVE_RAM -- requirements
Module: mem_slave_ram

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words in the RAM.
REQ-002 Parameter WAIT_CYCLES, default 0: extra wait cycles inserted before each mem_ready, legal range 0..15.
REQ-003 Parameter ADDR_LIMIT, default 1024: byte addresses >= ADDR_LIMIT are out of range.
REQ-004 clk  in  1  single clock; all logic SHALL act on its rising edge.
REQ-005 resetn  in  1  reset, synchronous and active-low.
REQ-006 mem_valid  in  1  core request valid, held until mem_ready is seen.
REQ-007 mem_instr  in  1  request is an instruction fetch.
REQ-008 mem_addr  in  32  byte address; bits [1:0] ignored.
REQ-009 mem_wdata  in  32  store data.
REQ-010 mem_wstrb  in  4  byte write strobes; 0000 means read.
REQ-011 mem_ready  out  1  one-cycle completion pulse.
REQ-012 mem_rdata  out  32  read data, valid while mem_ready=1.
REQ-013 ld_valid  in  1  preload write strobe, full word.
REQ-014 ld_addr  in  $clog2(DEPTH_WORDS)  preload word index.
REQ-015 ld_data  in  32  preload data.
REQ-016 st_pulse  out  1  one-cycle pulse on each committed in-range store.
REQ-017 st_addr  out  32  byte address of the last committed store.
REQ-018 st_data  out  32  full RAM word after the last committed store, with strobes applied.
REQ-019 bus_err  out  1  sticky flag, set by any out-of-range access.
REQ-020 fetch_cnt / store_cnt  out  16 each  saturating counts of completed fetches and in-range stores.

Function
REQ-021 FSM states SHALL be IDLE, WAIT and RESP; mem_ready SHALL be 1 only in RESP, and RESP SHALL last exactly one cycle before returning to IDLE.
REQ-022 In IDLE, when mem_valid=1 and ld_valid=0 at an edge:
- addr, wdata and wstrb SHALL be captured;
- next state SHALL be RESP if WAIT_CYCLES=0, else WAIT, with a down-counter loaded with WAIT_CYCLES-1.
REQ-023 In WAIT, the FSM SHALL move to RESP on the edge where the counter reads 0, so mem_ready rises WAIT_CYCLES+1 edges after mem_valid is first sampled.
REQ-024 On the RESP-entry edge, for an in-range address:
- mem_rdata SHALL load RAM[addr>>2] as it was before any write in that edge;
- each byte with its strobe set SHALL be written.
REQ-025 For an out-of-range access:
- mem_rdata SHALL be 0 and no RAM write SHALL occur;
- bus_err SHALL set, and mem_ready SHALL still pulse.
REQ-026 mem_rdata SHALL hold its last value outside RESP.
REQ-027 A store with any strobe set SHALL pulse st_pulse in the RESP cycle and update st_addr/st_data on the same edge; fetch_cnt SHALL increment on the RESP edge when mem_instr was captured as 1.
REQ-028 fetch_cnt and store_cnt SHALL saturate at 16'hFFFF.
REQ-029 ld_valid SHALL write RAM[ld_addr]=ld_data in any state.
REQ-030 If ld_valid=1 and mem_valid=1 coincide in IDLE, the preload SHALL win and bus acceptance SHALL defer until ld_valid=0.
REQ-031 If ld_valid targets the word being accessed in the RESP-entry edge, the bus write SHALL take priority.
REQ-032 mem_valid=0 in WAIT (protocol violation) SHALL NOT abort the transaction.

Reset
REQ-033 While resetn=0 at an edge:
- state SHALL go to IDLE;
- mem_ready, st_pulse and bus_err SHALL be 0;
- mem_rdata, st_addr, st_data, fetch_cnt and store_cnt SHALL be 0.
REQ-034 Reset mid-transaction SHALL drop the pending access with no RAM write, and RAM contents SHALL be retained across reset.
REQ-035 ld_valid SHALL still be honoured during reset.

Structure
REQ-036 Package mem_slave_pkg SHALL hold the state enum and the default values of DEPTH_WORDS, WAIT_CYCLES and ADDR_LIMIT.
REQ-037 Sub-module mem_slave_ram_array SHALL implement the byte-enabled single-write-port word RAM with read-before-write behaviour.

Verification
REQ-038 Preload word 1 with 0x00A00193, WAIT_CYCLES=0, fetch at 0x4 -> mem_ready one edge after valid, rdata 0x00A00193, fetch_cnt 1.
REQ-039 Store 0xDEADBEEF with wstrb 0101 to 0x8 over word 0x11223344 -> st_data 0x11AD33EF, st_addr 0x8, st_pulse one cycle, store_cnt 1.
REQ-040 WAIT_CYCLES=3, read 0x0 -> mem_ready exactly 4 edges after valid, high exactly one cycle.
REQ-041 Read 0x400 -> mem_ready pulses, rdata 0, bus_err stays 1 until reset.
REQ-042 resetn low in WAIT during a store to 0xC -> no ready pulse, word 3 unchanged, all outputs 0.
REQ-043 ld_valid and mem_valid asserted together for 2 cycles -> preload committed, bus accepted on the first cycle with ld_valid=0.
